// File: rtl/adder_share_arbiter_if.sv
// Bus bundle between adder_share_arbiter, its requesters and the shared adder.
// slave: arbiter side; master: requester/adder environment side.
interface adder_share_arbiter_if #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ*SIZE-1:0] op_a;
    logic [NUM_REQ*SIZE-1:0] op_b;
    logic [NUM_REQ-1:0]      grant;
    logic                    busy;
    logic                    done;
    logic [ID_W-1:0]         done_id;
    logic [SIZE:0]           result;
    logic [SIZE-1:0]         add_src1;
    logic [SIZE-1:0]         add_src2;
    logic [SIZE:0]           add_res;

    modport slave (
        input  req, op_a, op_b, add_res,
        output grant, busy, done, done_id, result, add_src1, add_src2
    );

    modport master (
        output req, op_a, op_b, add_res,
        input  grant, busy, done, done_id, result, add_src1, add_src2
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin time-sharing controller for one external adder among NUM_REQ requesters.
// Optional macro ADDER_ARB_STATS_EN adds a 16-bit op_count output counting completed EXEC cycles.
module adder_share_arbiter #(
    parameter int SIZE    = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic clk,
    input  logic rst,
    adder_share_arbiter_if.slave bus
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0] op_count
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     win;
    logic [ID_W-1:0]     ptr_next;
    logic                found;
    logic [SIZE-1:0]     a_arr [NUM_REQ];
    logic [SIZE-1:0]     b_arr [NUM_REQ];

    logic [NUM_REQ-1:0]  grant_q;
    logic                busy_q;
    logic                done_q;
    logic [ID_W-1:0]     id_q;
    logic [SIZE:0]       res_q;
    logic [SIZE-1:0]     src1_q;
    logic [SIZE-1:0]     src2_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = bus.op_a[g*SIZE +: SIZE];
        assign b_arr[g] = bus.op_b[g*SIZE +: SIZE];
    end

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ; first set req bit wins.
    always_comb begin
        int unsigned     idx;
        logic [ID_W-1:0] iw;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        iw    = '0;
        for (int unsigned k = 0; k < unsigned'(NUM_REQ); k++) begin
            idx = 32'(ptr) + k;
            if (idx >= unsigned'(NUM_REQ)) begin
                idx = idx - unsigned'(NUM_REQ);
            end
            iw = idx[ID_W-1:0];
            if (!found && bus.req[iw]) begin
                found = 1'b1;
                win   = iw;
            end
        end
    end

    assign ptr_next = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            id_q    <= '0;
            res_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (found) begin
                        grant_q <= NUM_REQ'(1) << win;
                        src1_q  <= a_arr[win];
                        src2_q  <= b_arr[win];
                        id_q    <= win;
                        ptr     <= ptr_next;
                        busy_q  <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_q  <= bus.add_res;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count <= '0;
        end else if (state == EXEC) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.done_id  = id_q;
    assign bus.result   = res_q;
    assign bus.add_src1 = src1_q;
    assign bus.add_src2 = src2_q;
endmodule
